led_pattern_gen: RTL

- Multi-channel, parametrised successor to the single fixed-rate status-LED flasher.
- Each of N_CH outputs is independently configured at runtime from the MCU register space: OFF, ON, BLINK at a programmable rate, or a repeating N-flash diagnostic code.
- One shared tick prescaler drives all channels.
- Sits beside mcu_main; outputs go to board LEDs, active-high (inversion is done at top level).

---
 rtl/led_pkg.sv | 32 +++
 rtl/led_channel.sv | 169 ++++++++++++++++
 rtl/led_pattern_gen.sv | 75 +++++++
 3 files changed

// File: rtl/led_pkg.sv
// Shared types, configuration field widths and sizing helpers for led_pattern_gen.
// Also defines the GET_WIDTH sizing macro used by the block's counters.
`ifndef GET_WIDTH
`define GET_WIDTH(x) (((x) < 1) ? 1 : $clog2((x) + 1))
`endif

package led_pkg;

  localparam int CFG_CH_W   = 4;
  localparam int CFG_MODE_W = 2;
  localparam int CFG_ARG_W  = 4;
  localparam int CFG_DUTY_W = 4;

  typedef enum logic [CFG_MODE_W-1:0] {
    LM_OFF,
    LM_ON,
    LM_BLINK,
    LM_CODE
  } led_mode_t;

  typedef enum logic [1:0] {
    CS_IDLE,
    CS_ON,
    CS_OFF,
    CS_GAP
  } code_state_t;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: OFF / ON / BLINK / repeating N-flash CODE, stepped by the shared tick.
// Optional LED_PWM_DIM_EN adds a per-channel duty gate in front of the output register.
module led_channel
  import led_pkg::*;
#(
  parameter int                   CODE_ON_TICKS  = 20,
  parameter int                   CODE_OFF_TICKS = 30,
  parameter int                   CODE_GAP_TICKS = 150,
  parameter led_mode_t            RST_MODE       = LM_OFF,
  parameter logic [CFG_ARG_W-1:0] RST_ARG        = '0
) (
  input  logic                  clk,
  input  logic                  aclr,
  input  logic                  tick,
  input  logic                  wr,
  input  led_mode_t             mode,
  input  logic [CFG_ARG_W-1:0]  arg,
`ifdef LED_PWM_DIM_EN
  input  logic [CFG_DUTY_W-1:0] duty,
`endif
  output logic                  led
);

  // One phase counter serves both BLINK (up to max arg) and the CODE segments.
  localparam int MAX_T = imax(imax(CODE_ON_TICKS, CODE_OFF_TICKS),
                              imax(CODE_GAP_TICKS, 2**CFG_ARG_W - 1));
  localparam int TW    = `GET_WIDTH(MAX_T);

  localparam logic [TW-1:0] ON_LAST  = TW'(CODE_ON_TICKS - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(CODE_OFF_TICKS - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(CODE_GAP_TICKS - 1);

  led_mode_t             mode_q,  mode_d;
  logic [CFG_ARG_W-1:0]  arg_q,   arg_d;
  logic [TW-1:0]         phase_q, phase_d;
  logic [CFG_ARG_W-1:0]  flash_q, flash_d;
  code_state_t           state_q, state_d;
  logic                  blink_q, blink_d;
  logic                  led_q,   led_d;
  logic                  pattern;
`ifdef LED_PWM_DIM_EN
  logic [CFG_DUTY_W-1:0] duty_q,  duty_d;
  logic [CFG_DUTY_W-1:0] pwm_q,   pwm_d;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    mode_d  = mode_q;
    arg_d   = arg_q;
    phase_d = phase_q;
    flash_d = flash_q;
    state_d = state_q;
    blink_d = blink_q;

    if (wr) begin
      // A write wins over a coincident tick: the new pattern starts from phase 0.
      mode_d  = mode;
      arg_d   = arg;
      phase_d = '0;
      flash_d = '0;
      state_d = CS_IDLE;
      blink_d = 1'b0;
    end else if (tick) begin
      case (mode_q)
        LM_BLINK: begin
          if (phase_q == TW'(arg_q)) begin
            phase_d = '0;
            blink_d = ~blink_q;
          end else begin
            phase_d = phase_q + TW'(1);
          end
        end
        LM_CODE: begin
          case (state_q)
            CS_IDLE: begin
              if (arg_q != '0) begin
                state_d = CS_ON;
                flash_d = CFG_ARG_W'(1);
                phase_d = '0;
              end
            end
            CS_ON: begin
              if (phase_q == ON_LAST) begin
                phase_d = '0;
                state_d = CS_OFF;
              end else begin
                phase_d = phase_q + TW'(1);
              end
            end
            CS_OFF: begin
              if (phase_q == OFF_LAST) begin
                phase_d = '0;
                if (flash_q < arg_q) begin
                  state_d = CS_ON;
                  flash_d = flash_q + CFG_ARG_W'(1);
                end else begin
                  state_d = CS_GAP;
                end
              end else begin
                phase_d = phase_q + TW'(1);
              end
            end
            CS_GAP: begin
              if (phase_q == GAP_LAST) begin
                phase_d = '0;
                state_d = CS_ON;
                flash_d = CFG_ARG_W'(1);
              end else begin
                phase_d = phase_q + TW'(1);
              end
            end
            default: state_d = CS_IDLE;
          endcase
        end
        default: ;
      endcase
    end

    // Pattern is decoded from next-state values so led_q follows a write by one clk.
    case (mode_d)
      LM_ON:    pattern = 1'b1;
      LM_BLINK: pattern = blink_d;
      LM_CODE:  pattern = (state_d == CS_ON);
      default:  pattern = 1'b0;
    endcase

`ifdef LED_PWM_DIM_EN
    duty_d = wr ? duty : duty_q;
    pwm_d  = pwm_q + CFG_DUTY_W'(1);
    led_d  = pattern && (pwm_q <= duty_d);
`else
    led_d  = pattern;
`endif
  end

  // NOTE: state registers use non-blocking assignments only; every flop here is
  // small control state, so all of it is cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      mode_q  <= RST_MODE;
      arg_q   <= RST_ARG;
      phase_q <= '0;
      flash_q <= '0;
      state_q <= CS_IDLE;
      blink_q <= 1'b0;
      led_q   <= 1'b0;
`ifdef LED_PWM_DIM_EN
      duty_q  <= '1;
      pwm_q   <= '0;
`endif
    end else begin
      mode_q  <= mode_d;
      arg_q   <= arg_d;
      phase_q <= phase_d;
      flash_q <= flash_d;
      state_q <= state_d;
      blink_q <= blink_d;
      led_q   <= led_d;
`ifdef LED_PWM_DIM_EN
      duty_q  <= duty_d;
      pwm_q   <= pwm_d;
`endif
    end
  end

  assign led = led_q;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared tick prescaler, config write decode, channel array.
// Build with LED_PWM_DIM_EN defined to add the cfg_duty port and per-channel PWM dimming.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int          SYS_CLOCK      = 72_000_000,
  parameter int          TICK_HZ        = 100,
  parameter int          N_CH           = 4,
  parameter int          CODE_ON_TICKS  = 20,
  parameter int          CODE_OFF_TICKS = 30,
  parameter int          CODE_GAP_TICKS = 150,
  parameter logic [15:0] RST_BLINK_MASK = 16'h1
) (
  input  logic                  clk,
  input  logic                  aclr,
  input  logic                  cfg_we,
  input  logic [CFG_CH_W-1:0]   cfg_ch,
  input  logic [CFG_MODE_W-1:0] cfg_mode,
  input  logic [CFG_ARG_W-1:0]  cfg_arg,
`ifdef LED_PWM_DIM_EN
  input  logic [CFG_DUTY_W-1:0] cfg_duty,
`endif
  output logic                  tick,
  output logic [N_CH-1:0]       led
);

  localparam int PRE_MAX = SYS_CLOCK / TICK_HZ - 1;
  localparam int PRE_W   = `GET_WIDTH(PRE_MAX);

  if (SYS_CLOCK < 2 * TICK_HZ) begin : g_bad_clock
    $error("led_pattern_gen: SYS_CLOCK must be at least 2*TICK_HZ");
  end
  if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
    $error("led_pattern_gen: N_CH must be in 1..16");
  end

  logic [PRE_W-1:0] pre_q, pre_d;

  always_comb begin
    pre_d = (pre_q == PRE_W'(PRE_MAX)) ? '0 : pre_q + PRE_W'(1);
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) pre_q <= '0;
    else      pre_q <= pre_d;
  end

  assign tick = (pre_q == PRE_W'(PRE_MAX));

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    // Indices at or above N_CH match no channel, so such writes fall through.
    logic wr;
    assign wr = cfg_we && (cfg_ch == CFG_CH_W'(i));

    led_channel #(
      .CODE_ON_TICKS  (CODE_ON_TICKS),
      .CODE_OFF_TICKS (CODE_OFF_TICKS),
      .CODE_GAP_TICKS (CODE_GAP_TICKS),
      .RST_MODE       (RST_BLINK_MASK[i] ? LM_BLINK : LM_OFF),
      .RST_ARG        (RST_BLINK_MASK[i] ? 4'd9 : 4'd0)
    ) u_ch (
      .clk  (clk),
      .aclr (aclr),
      .tick (tick),
      .wr   (wr),
      .mode (led_mode_t'(cfg_mode)),
      .arg  (cfg_arg),
`ifdef LED_PWM_DIM_EN
      .duty (cfg_duty),
`endif
      .led  (led[i])
    );
  end

endmodule
